ahb_mem_slave: RTL and testbench
================================

# ahb_mem_slave

AHB-lite responder fronting a single-port synchronous SRAM; the memory-side end of the bus driven by `ibusif` and the data-side bus interface. It accepts single transfers (1-bit `htrans` valid, no bursts), returns full 32-bit read words, and commits byte-lane writes. It also inserts configurable wait states and issues two-cycle error responses. It sits directly behind the core's instruction/data bus as boot/program memory in single-master systems and unit benches.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, word-address bits; capacity 4·2^ADDR_WIDTH bytes (default 4 KiB)
- `BASE`, 32'h0000_0000, byte base address; must be aligned to capacity
- `WAIT_STATES`, 0, extra `hready`-low cycles per successful data phase (0..15)

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `haddr`  in  32  byte address (address phase)
- `hprot`  in  1  data/instruction indicator; does not affect the response
- `hsize`  in  2  0 byte, 1 halfword, 2 word, 3 illegal
- `hwrite`  in  1  1 write, 0 read
- `hwdata`  in  32  write data, lane-positioned (data phase)
- `htrans`  in  1  transfer valid (bit 1 of HTRANS)
- `hrdata`  out  32  read word, unshifted, from aligned word address
- `hresp`  out  1  1 error
- `hready`  out  1  transfer complete / address phase accepted

## Operation
- Address phase is accepted on a rising edge where `htrans & hready`. Capture `haddr`, `hsize`, and `hwrite`.
- Error conditions are any of: `haddr[31:ADDR_WIDTH+2] != BASE[31:ADDR_WIDTH+2]`; `hsize==3`; misalignment (see Configuration). An error overrides wait states. An errored write never touches memory.
- FSM states:
  - IDLE: no data phase pending; `hready=1`, `hresp=0`.
  - DATA: `hready=1` only in the final cycle.
  - ERR1: `hready=0`, `hresp=1`.
  - ERR2: `hready=1`, `hresp=1`.
- Transitions:
  - Accepted OK transfer → DATA. Accepted errored transfer → ERR1 → ERR2.
  - Leaving DATA or ERR2: if a new transfer is accepted in the same cycle, go to DATA or ERR1; otherwise go to IDLE.
- Read: the SRAM read is issued with the address-phase `haddr` word index. `hrdata` is the SRAM output register and holds its value until the next read is issued.
- Write: byte enables are derived from `hsize` and `haddr[1:0]`. Write to SRAM happens on the edge ending the write's final data cycle (`hready=1`), using `hwdata`.
- Port conflict: a read accepted in the final data cycle of a write loses the port. Its read issues in its first data cycle, adding exactly 1 wait state on top of `WAIT_STATES`. Because the write commits first, the read returns the new data.
- Wait counter: loaded with `WAIT_STATES` (+1 on conflict) on acceptance, decrements each DATA cycle, and `hready` goes high when it reaches 0.

## Timing
- Reset values: `hready=1`, `hresp=0`, `hrdata=0`, state IDLE, counter 0.
- Reset mid-transfer aborts the transfer; a write in progress is not committed.
- Read latency: address accepted at edge N → `hrdata` valid in cycle N+1+WAIT_STATES with `hready=1`.
- Error: cycle N+1 `hready=0,hresp=1`; cycle N+2 `hready=1,hresp=1`. A new address phase may be accepted at the end of N+2.
- Back-to-back transfers with no conflict sustain one transfer per 1+WAIT_STATES cycles.
- `hresp` returns to 0 in the first cycle after ERR2 unless a new error follows.

## Configuration
- `AHB_MEM_SLAVE_ALIGN_CHK_EN` defined: halfword with `haddr[0]=1`, or word with `haddr[1:0]!=0`, is an error response.
- Not defined: low address bits below the access size are ignored. The access is treated as aligned down (byte enables computed on the aligned address) and no error is raised.

## Structure
- Shared package `ahb_pkg`: `hsize` constants (`HSIZE_BYTE/HALF/WORD`), the FSM state enum, and the byte-enable function (`hsize`, `addr[1:0]`) → `be[3:0]`.
- One sub-module, `spram_be`: single-port synchronous SRAM, 32-bit, 4 byte enables, registered read output, 2^ADDR_WIDTH words.
- `ahb_mem_slave` contains the FSM, wait counter, conflict detect, and error decode.

## Test plan
- Reset → `hready=1`, `hresp=0`, `hrdata=0`. Idle `htrans=0` for 10 cycles → `hready` stays 1.
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then back-to-back read @0x10 → read `hready` low exactly 1 cycle, then `hrdata=0xDEADBEEF`.
- Byte write `hsize=0` @0x11, `hwdata=0x0000AB00`, then word read @0x10 → `hrdata=0xDEADABEF`.
- ADDR_WIDTH=10: read @0x0000_1000 → `hready` 0 then 1 with `hresp` 1,1. Write there → memory unchanged.
- WAIT_STATES=2: read @0x0 → `hready` low 2 cycles, high on the 3rd with valid data. Next back-to-back read also takes 3 cycles.
- Halfword write 0x1234_0000 @0x13: with `AHB_MEM_SLAVE_ALIGN_CHK_EN` → two-cycle error and memory unchanged. Without it → written at 0x12, and a word read @0x10 returns upper half 0x1234.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions: transfer sizes, responder FSM states, byte-lane decode.
package ahb_pkg;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Lanes come from the aligned-down address, so stray low bits never widen the write.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr;
      HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: byte_en = 4'b1111;
      default:    byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/spram_be.sv
// Single-port synchronous SRAM, 32-bit words with byte enables; one-cycle registered read.
module spram_be #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Output register only changes on a read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-lite SRAM responder: single transfers, WAIT_STATES extra data cycles, two-cycle error response.
// hready backpressures the master; AHB_MEM_SLAVE_ALIGN_CHK_EN turns misaligned half/word accesses into errors.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] haddr,
  input  logic        hprot,
  input  logic [1:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        htrans,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic        hready
);

  localparam logic [31:0] HI_MASK = ~((32'd4 << ADDR_WIDTH) - 32'd1);
  localparam logic [4:0]  WS      = 5'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic                    late_q, late_d;
  logic [ADDR_WIDTH-1:0]   widx_q, widx_d;
  logic [1:0]              lo_q, lo_d;
  logic [1:0]              size_q, size_d;

  logic                    accept, req_err, align_err, conflict;
  logic                    wr_commit, rd_now, mem_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    unused_ok;

  assign unused_ok = hprot;

`ifdef AHB_MEM_SLAVE_ALIGN_CHK_EN
  assign align_err = ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign accept    = htrans && hready;
  assign req_err   = ((haddr & HI_MASK) != (BASE & HI_MASK)) || (hsize == 2'd3) || align_err;
  assign wr_commit = (state_q == ST_DATA) && wr_q && hready;
  // A read arriving while a write commits loses the port and issues one cycle later.
  assign conflict  = accept && !req_err && !hwrite && wr_commit;
  assign rd_now    = accept && !req_err && !hwrite && !wr_commit;
  assign mem_en    = rstn && (wr_commit || rd_now || late_q);
  assign mem_addr  = (wr_commit || late_q) ? widx_q : haddr[ADDR_WIDTH+1:2];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      late_q  <= 1'b0;
      widx_q  <= '0;
      lo_q    <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      late_q  <= late_d;
      widx_q  <= widx_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    late_d  = 1'b0;
    widx_d  = widx_q;
    lo_d    = lo_q;
    size_d  = size_q;
    if (state_q == ST_DATA && cnt_q != '0) cnt_d = cnt_q - 5'd1;
    if (accept) begin
      widx_d = haddr[ADDR_WIDTH+1:2];
      lo_d   = haddr[1:0];
      size_d = hsize;
      if (req_err) begin
        state_d = ST_ERR1;
        cnt_d   = '0;
        wr_d    = 1'b0;
      end else begin
        state_d = ST_DATA;
        cnt_d   = WS + {4'b0000, conflict};
        wr_d    = hwrite;
        late_d  = conflict;
      end
    end else begin
      case (state_q)
        ST_DATA: state_d = hready ? ST_IDLE : ST_DATA;
        ST_ERR1: state_d = ST_ERR2;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    case (state_q)
      ST_DATA: hready = (cnt_q == '0);
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  spram_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .en_i    (mem_en),
    .we_i    (wr_commit),
    .be_i    (byte_en(size_q, lo_q)),
    .addr_i  (mem_addr),
    .wdata_i (hwdata),
    .rdata_o (hrdata)
  );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: one zero-wait and one two-wait instance driven from a vector table.
module tb_ahb_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [31:0] haddr, hwdata;
  logic        hprot, hwrite, htrans0, htrans2;
  logic [1:0]  hsize;
  logic [31:0] hrdata0, hrdata2;
  logic        hresp0, hresp2, hready0, hready2;

`ifdef AHB_MEM_SLAVE_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  ahb_mem_slave #(.ADDR_WIDTH(10), .BASE(32'h0), .WAIT_STATES(0)) u0 (
    .clk(clk), .rstn(rstn), .haddr(haddr), .hprot(hprot), .hsize(hsize), .hwrite(hwrite),
    .hwdata(hwdata), .htrans(htrans0), .hrdata(hrdata0), .hresp(hresp0), .hready(hready0));

  ahb_mem_slave #(.ADDR_WIDTH(10), .BASE(32'h0), .WAIT_STATES(2)) u2 (
    .clk(clk), .rstn(rstn), .haddr(haddr), .hprot(hprot), .hsize(hsize), .hwrite(hwrite),
    .hwdata(hwdata), .htrans(htrans2), .hrdata(hrdata2), .hresp(hresp2), .hready(hready2));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          gap;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  vec_t vec[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit wr, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                     input int gap, input bit err, input logic [31:0] rd);
    vec.push_back('{wr, a, s, d, gap, err, rd});
  endtask

  task automatic sample(input bit sel, output logic rdy, output logic rsp, output logic [31:0] rd);
    rdy = sel ? hready2 : hready0;
    rsp = sel ? hresp2  : hresp0;
    rd  = sel ? hrdata2 : hrdata0;
  endtask

  // Pipelined master: next address phase overlaps the current data phase.
  task automatic run(input bit sel, input int first, input int last, input int ws);
    int          i      = first;
    int          gap    = vec[first].gap;
    bit          dp     = 1'b0;
    int          cyc    = 0;
    int          guard  = 0;
    logic [31:0] dwdata = '0;
    logic        first_rsp = 1'b0;
    logic        rdy, rsp;
    logic [31:0] rd;
    bit          pres, okw_done, conf;
    exp_t        e;
    while ((i <= last || dp) && guard < 500) begin
      guard++;
      okw_done = 1'b0;
      pres     = (i <= last) && (gap == 0);
      htrans0  = pres && !sel;
      htrans2  = pres && sel;
      hprot    = 1'($urandom);
      if (pres) begin
        haddr  = vec[i].addr;
        hsize  = vec[i].size;
        hwrite = vec[i].wr;
      end
      hwdata = dwdata;
      @(negedge clk);
      sample(sel, rdy, rsp, rd);
      if (dp) begin
        cyc++;
        if (cyc == 1) first_rsp = rsp;
        if (rdy) begin
          e = sb.pop_front();
          chk("data_cycles", cyc, e.cyc);
          chk("hresp_first", {31'b0, first_rsp}, {31'b0, e.err});
          chk("hresp_last", {31'b0, rsp}, {31'b0, e.err});
          if (!e.wr && !e.err) chk("hrdata", rd, e.rdata);
          okw_done = e.wr && !e.err;
          dp = 1'b0;
        end
      end else begin
        chk("idle_ready_resp", {30'b0, rdy, rsp}, 32'h2);
      end
      if (pres && rdy) begin
        conf = okw_done && !vec[i].wr;
        sb.push_back('{vec[i].wr, vec[i].err, vec[i].rdata, vec[i].err ? 2 : 1 + ws + int'(conf)});
        dp     = 1'b1;
        cyc    = 0;
        dwdata = vec[i].wdata;
        i++;
        if (i <= last) gap = vec[i].gap;
      end else if (!pres && gap > 0) begin
        gap--;
      end
      @(posedge clk);
      #1;
    end
    htrans0 = 1'b0;
    htrans2 = 1'b0;
    if (guard >= 500) chk("run_timeout", 32'd1, 32'd0);
  endtask

  int n0, n1;

  initial begin
    rstn = 1'b0; htrans0 = 1'b0; htrans2 = 1'b0; haddr = '0; hsize = '0;
    hwrite = 1'b0; hwdata = '0; hprot = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hready0", {31'b0, hready0}, 32'd1);
    chk("rst_hresp0", {31'b0, hresp0}, 32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_hready2", {31'b0, hready2}, 32'd1);
    chk("rst_hrdata2", hrdata2, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle10_hready", {31'b0, hready0}, 32'd1);
    end
    @(posedge clk);
    #1;

    // wr, addr, size, wdata, gap, err, expected rdata
    add(1, 32'h10,   2, 32'hDEADBEEF, 0, 0,     '0);
    add(0, 32'h10,   2, '0,           0, 0,     32'hDEADBEEF);
    add(1, 32'h11,   0, 32'h0000AB00, 0, 0,     '0);
    add(0, 32'h10,   2, '0,           0, 0,     32'hDEADABEF);
    add(1, 32'h00,   2, 32'h11111111, 1, 0,     '0);
    add(0, 32'h1000, 2, '0,           0, 1,     '0);
    add(1, 32'h1000, 2, 32'h55555555, 0, 1,     '0);
    add(0, 32'h00,   2, '0,           0, 0,     32'h11111111);
    add(0, 32'h10,   3, '0,           0, 1,     '0);
    add(1, 32'h13,   1, 32'h12340000, 0, ALIGN, '0);
    add(0, 32'h10,   2, '0,           0, 0,     ALIGN ? 32'hDEADABEF : 32'h1234ABEF);
    add(1, 32'h20,   2, 32'hA5A5A5A5, 2, 0,     '0);
    add(1, 32'h23,   0, 32'h77000000, 0, 0,     '0);
    add(1, 32'h20,   1, 32'h0000BEEF, 0, 0,     '0);
    add(0, 32'h20,   2, '0,           0, 0,     32'h77A5BEEF);
    add(1, 32'h30,   2, 32'hCAFEF00D, 0, 0,     '0);
    add(0, 32'h30,   2, '0,           1, 0,     32'hCAFEF00D);
    add(0, 32'h31,   0, '0,           0, 0,     32'hCAFEF00D);
    add(0, 32'h32,   2, '0,           0, ALIGN, 32'hCAFEF00D);
    n0 = vec.size();
    add(1, 32'h00,   2, 32'h89ABCDEF, 0, 0,     '0);
    add(0, 32'h00,   2, '0,           0, 0,     32'h89ABCDEF);
    add(0, 32'h00,   2, '0,           0, 0,     32'h89ABCDEF);
    add(0, 32'h1000, 2, '0,           0, 1,     '0);
    add(0, 32'h00,   2, '0,           0, 0,     32'h89ABCDEF);
    add(1, 32'h40,   2, 32'h01020304, 0, 0,     '0);
    n1 = vec.size();
    add(0, 32'h40,   2, '0,           0, 0,     32'h01020304);

    run(1'b0, 0, n0 - 1, 0);
    run(1'b1, n0, n1 - 1, 2);

    // Reset lands in the final data cycle of a write: the write must be dropped.
    haddr = 32'h40; hsize = 2'd2; hwrite = 1'b1; htrans2 = 1'b1;
    @(negedge clk);
    chk("rstseq_accept_ready", {31'b0, hready2}, 32'd1);
    @(posedge clk);
    #1 htrans2 = 1'b0; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rstseq_wait_ready", {31'b0, hready2}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstseq_final_ready", {31'b0, hready2}, 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstseq_hready", {31'b0, hready2}, 32'd1);
    chk("rstseq_hresp", {31'b0, hresp2}, 32'd0);
    chk("rstseq_hrdata", hrdata2, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    run(1'b1, n1, n1, 2);

    if (sb.size() != 0) chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
